// File: rtl/enemy_spawn_ctrl.sv
// enemy_spawn_ctrl: per-frame enemy fleet scheduler (move, retire, spawn) over NUM_ENEMY slots.
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   frame_tick         one-cycle pulse per video frame; starts a MOVE/RETIRE/SPAWN sequence
//   game_en            game running; low while idle clears the fleet and the spawn counter
//   hit_valid, hit_idx collision report clearing one slot's active bit
//   enemy_x, enemy_y   packed 12-bit positions, slot i at [12i+11:12i]
//   enemy_active       per-slot valid
//   spawn_pulse        one-cycle pulse after a spawn
//   escape_pulse       one-cycle pulse after a frame in which enemies reached the left edge
//   busy               high while a frame sequence is in progress
// Build option: define LFSR_LANE_EN to pick spawn lanes from a 10-bit LFSR instead of
// the fixed sequential lane order.
module enemy_spawn_ctrl #(
    parameter int          NUM_ENEMY      = 4,
    parameter logic [11:0] SPAWN_X        = 12'd1000,
    parameter logic [11:0] LEFT_EDGE      = 12'd30,
    parameter logic [11:0] STEP           = 12'd4,
    parameter int          SPAWN_INTERVAL = 60
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_tick,
    input  logic                    game_en,
    input  logic                    hit_valid,
    input  logic [2:0]              hit_idx,
    output logic [12*NUM_ENEMY-1:0] enemy_x,
    output logic [12*NUM_ENEMY-1:0] enemy_y,
    output logic [NUM_ENEMY-1:0]    enemy_active,
    output logic                    spawn_pulse,
    output logic                    escape_pulse,
    output logic                    busy
);
    localparam int CW = $clog2(SPAWN_INTERVAL + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(SPAWN_INTERVAL);

    typedef enum logic [1:0] {IDLE, MOVE, RETIRE, SPAWN} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [NUM_ENEMY-1:0] esc_mask, free_mask, active_nxt;
    logic                 cnt_full, do_spawn, idle_off;
    logic [2:0]           lane_sel;
    logic [11:0]          lane_y;

`ifdef LFSR_LANE_EN
    logic [9:0] lfsr;
    // Fibonacci LFSR, taps 10 and 7; the all-zero lock-up state reloads the seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr <= 10'd233;
        else if (frame_tick)
            lfsr <= (lfsr == 10'd0) ? 10'd233 : {lfsr[8:0], lfsr[9] ^ lfsr[6]};
    end
    assign lane_sel = 3'(lfsr % 10'd7);
`else
    logic [2:0] lane_idx;
    // Lane order continues across games; only reset rewinds it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lane_idx <= 3'd0;
        else if (do_spawn)
            lane_idx <= (lane_idx == 3'd6) ? 3'd0 : lane_idx + 3'd1;
    end
    assign lane_sel = lane_idx;
`endif

    always_comb begin
        lane_y = 12'd350;
        case (lane_sel)
            3'd0:    lane_y = 12'd350;
            3'd1:    lane_y = 12'd550;
            3'd2:    lane_y = 12'd250;
            3'd3:    lane_y = 12'd450;
            3'd4:    lane_y = 12'd370;
            3'd5:    lane_y = 12'd630;
            3'd6:    lane_y = 12'd130;
            default: lane_y = 12'd350;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = (frame_tick && game_en) ? MOVE : IDLE;
            MOVE:    state_nxt = RETIRE;
            RETIRE:  state_nxt = SPAWN;
            SPAWN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_comb begin
        esc_mask = '0;
        for (int i = 0; i < NUM_ENEMY; i++)
            esc_mask[i] = enemy_active[i] && (enemy_x[12*i +: 12] <= LEFT_EDGE);
    end

    // Isolates the lowest clear bit of the active mask: the lowest-index free slot.
    assign free_mask = ~enemy_active & (enemy_active + NUM_ENEMY'(1));
    assign cnt_full  = (cnt == CNT_MAX);
    assign do_spawn  = (state == SPAWN) && cnt_full && (|free_mask);
    assign idle_off  = (state == IDLE) && !game_en;

    // Hits are applied before the spawn so a hit on the slot being filled (free, so
    // inactive) cannot cancel the spawn.
    always_comb begin
        active_nxt = enemy_active;
        if (idle_off)
            active_nxt = '0;
        if (state == RETIRE)
            active_nxt = active_nxt & ~esc_mask;
        for (int i = 0; i < NUM_ENEMY; i++)
            if (hit_valid && hit_idx == 3'(i))
                active_nxt[i] = 1'b0;
        if (do_spawn)
            active_nxt = active_nxt | free_mask;
    end

    // Retired slots keep their last position; only MOVE and SPAWN write positions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enemy_x <= '0;
            enemy_y <= '0;
        end else begin
            for (int i = 0; i < NUM_ENEMY; i++) begin
                if (state == MOVE && enemy_active[i])
                    enemy_x[12*i +: 12] <= (enemy_x[12*i +: 12] >= STEP) ? enemy_x[12*i +: 12] - STEP : 12'd0;
                else if (do_spawn && free_mask[i]) begin
                    enemy_x[12*i +: 12] <= SPAWN_X;
                    enemy_y[12*i +: 12] <= lane_y;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enemy_active <= '0;
            cnt          <= '0;
            spawn_pulse  <= 1'b0;
            escape_pulse <= 1'b0;
        end else begin
            enemy_active <= active_nxt;
            spawn_pulse  <= do_spawn;
            escape_pulse <= (state == RETIRE) && (|esc_mask);
            if (idle_off || do_spawn)
                cnt <= '0;
            else if (state == MOVE && !cnt_full)
                cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_enemy_spawn_ctrl.sv
// tb_enemy_spawn_ctrl: directed self-checking bench for enemy_spawn_ctrl (default lane order).
module tb_enemy_spawn_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        game_en = 1'b0;
    logic        hit_valid = 1'b0;
    logic [2:0]  hit_idx = 3'd0;
    logic [47:0] enemy_x, enemy_y;
    logic [3:0]  enemy_active;
    logic        spawn_pulse, escape_pulse, busy;

    int          errors = 0;
    int          checks = 0;
    int          nsp;
    logic        sp, ep, mv_busy;
    logic [3:0]  act_ret;

    enemy_spawn_ctrl dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .game_en(game_en),
        .hit_valid(hit_valid), .hit_idx(hit_idx), .enemy_x(enemy_x), .enemy_y(enemy_y),
        .enemy_active(enemy_active), .spawn_pulse(spawn_pulse), .escape_pulse(escape_pulse),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] xs(input int i);
        return enemy_x[12*i +: 12];
    endfunction

    function automatic logic [11:0] ys(input int i);
        return enemy_y[12*i +: 12];
    endfunction

    // One full frame sequence; hp selects the state in which a hit is held (1 MOVE, 2 RETIRE, 3 SPAWN).
    task automatic frame(input int hp, input logic [2:0] hi);
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0; mv_busy = busy; hit_idx = hi; hit_valid = (hp == 1);
        @(negedge clk); hit_valid = (hp == 2);
        @(negedge clk); ep = escape_pulse; act_ret = enemy_active; hit_valid = (hp == 3);
        @(negedge clk); sp = spawn_pulse; hit_valid = 1'b0;
    endtask

    task automatic run(input int n);
        nsp = 0;
        repeat (n) begin
            frame(0, 3'd0);
            nsp += int'(sp);
        end
    endtask

    task automatic idle_hit(input logic [2:0] hi);
        @(negedge clk); hit_valid = 1'b1; hit_idx = hi;
        @(negedge clk); hit_valid = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if (enemy_active !== 4'b0000) begin errors++; $display("FAIL reset_active got %b exp 0000", enemy_active); end
        checks++; if (enemy_x !== 48'd0 || enemy_y !== 48'd0) begin errors++; $display("FAIL reset_pos got x=%h y=%h exp 0", enemy_x, enemy_y); end
        checks++; if ({busy, spawn_pulse, escape_pulse} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got %b exp 000", {busy, spawn_pulse, escape_pulse}); end
        rst_n = 1'b1;
        game_en = 1'b1;
    endtask

    task automatic test_first_spawn;
        run(59);
        checks++; if (nsp !== 0 || enemy_active !== 4'b0000) begin errors++; $display("FAIL early_spawn got spawns=%0d active=%b exp 0 0000", nsp, enemy_active); end
        checks++; if (mv_busy !== 1'b1) begin errors++; $display("FAIL busy_move got %b exp 1", mv_busy); end
        frame(0, 3'd0);
        checks++; if (sp !== 1'b1) begin errors++; $display("FAIL spawn60_pulse got %b exp 1", sp); end
        checks++; if (enemy_active !== 4'b0001 || xs(0) !== 12'd1000 || ys(0) !== 12'd350) begin errors++; $display("FAIL spawn60 got act=%b x=%0d y=%0d exp 0001 1000 350", enemy_active, xs(0), ys(0)); end
        @(negedge clk);
        checks++; if (spawn_pulse !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL spawn_width got pulse=%b busy=%b exp 0 0", spawn_pulse, busy); end
    endtask

    task automatic test_second_spawn;
        run(59);
        checks++; if (nsp !== 0) begin errors++; $display("FAIL mid_spawn got %0d exp 0", nsp); end
        frame(0, 3'd0);
        checks++; if (xs(0) !== 12'd760 || xs(1) !== 12'd1000 || ys(1) !== 12'd550 || enemy_active !== 4'b0011) begin errors++; $display("FAIL spawn120 got x0=%0d x1=%0d y1=%0d act=%b exp 760 1000 550 0011", xs(0), xs(1), ys(1), enemy_active); end
        run(60);
        checks++; if (nsp !== 1 || enemy_active !== 4'b0111 || ys(2) !== 12'd250) begin errors++; $display("FAIL spawn180 got n=%0d act=%b y2=%0d exp 1 0111 250", nsp, enemy_active, ys(2)); end
        run(60);
        checks++; if (nsp !== 1 || enemy_active !== 4'b1111 || ys(3) !== 12'd450 || xs(0) !== 12'd280) begin errors++; $display("FAIL spawn240 got n=%0d act=%b y3=%0d x0=%0d exp 1 1111 450 280", nsp, enemy_active, ys(3), xs(0)); end
    endtask

    task automatic test_full;
        run(59);
        frame(0, 3'd0);
        checks++; if (sp !== 1'b0 || enemy_active !== 4'b1111 || xs(0) !== 12'd40) begin errors++; $display("FAIL full300 got sp=%b act=%b x0=%0d exp 0 1111 40", sp, enemy_active, xs(0)); end
        idle_hit(3'd5);
        checks++; if (enemy_active !== 4'b1111) begin errors++; $display("FAIL hit_oob got %b exp 1111", enemy_active); end
        idle_hit(3'd2);
        checks++; if (enemy_active !== 4'b1011) begin errors++; $display("FAIL hit_slot2 got %b exp 1011", enemy_active); end
        frame(0, 3'd0);
        checks++; if (sp !== 1'b1 || enemy_active !== 4'b1111 || xs(2) !== 12'd1000 || ys(2) !== 12'd370 || xs(0) !== 12'd36) begin errors++; $display("FAIL respawn2 got sp=%b act=%b x2=%0d y2=%0d x0=%0d exp 1 1111 1000 370 36", sp, enemy_active, xs(2), ys(2), xs(0)); end
    endtask

    task automatic test_escape;
        frame(0, 3'd0);
        checks++; if (sp !== 1'b0 || ep !== 1'b0 || xs(0) !== 12'd32) begin errors++; $display("FAIL pre_escape got sp=%b ep=%b x0=%0d exp 0 0 32", sp, ep, xs(0)); end
        frame(0, 3'd0);
        checks++; if (ep !== 1'b1 || act_ret[0] !== 1'b0) begin errors++; $display("FAIL escape got ep=%b act=%b exp 1 xxx0", ep, act_ret); end
        checks++; if (enemy_active !== 4'b1110 || xs(0) !== 12'd28 || ys(0) !== 12'd350 || escape_pulse !== 1'b0) begin errors++; $display("FAIL escape_after got act=%b x0=%0d y0=%0d ep=%b exp 1110 28 350 0", enemy_active, xs(0), ys(0), escape_pulse); end
    endtask

    task automatic test_hit_races;
        run(57);
        frame(3, 3'd0);
        checks++; if (sp !== 1'b1 || enemy_active !== 4'b1111 || xs(0) !== 12'd1000 || ys(0) !== 12'd630) begin errors++; $display("FAIL hit_spawn got sp=%b act=%b x0=%0d y0=%0d exp 1 1111 1000 630", sp, enemy_active, xs(0), ys(0)); end
        frame(0, 3'd0);
        frame(2, 3'd1);
        checks++; if (ep !== 1'b1 || enemy_active !== 4'b1101) begin errors++; $display("FAIL hit_retire got ep=%b act=%b exp 1 1101", ep, enemy_active); end
        run(57);
        frame(0, 3'd0);
        checks++; if (sp !== 1'b1 || enemy_active !== 4'b1111 || ys(1) !== 12'd130 || xs(0) !== 12'd760) begin errors++; $display("FAIL spawn7 got sp=%b act=%b y1=%0d x0=%0d exp 1 1111 130 760", sp, enemy_active, ys(1), xs(0)); end
        run(48);
        frame(1, 3'd3);
        checks++; if (enemy_active !== 4'b0111) begin errors++; $display("FAIL hit_move got %b exp 0111", enemy_active); end
        run(10);
        frame(0, 3'd0);
        checks++; if (sp !== 1'b1 || enemy_active !== 4'b1111 || ys(3) !== 12'd350 || xs(3) !== 12'd1000) begin errors++; $display("FAIL lane_wrap got sp=%b act=%b y3=%0d x3=%0d exp 1 1111 350 1000", sp, enemy_active, ys(3), xs(3)); end
    endtask

    task automatic test_game_off;
        run(10);
        @(negedge clk); game_en = 1'b0; frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        checks++; if (busy !== 1'b0 || enemy_active !== 4'b0000) begin errors++; $display("FAIL game_off got busy=%b act=%b exp 0 0000", busy, enemy_active); end
        game_en = 1'b1;
        run(59);
        checks++; if (nsp !== 0) begin errors++; $display("FAIL game_off_cnt got %0d spawns exp 0", nsp); end
        frame(0, 3'd0);
        checks++; if (sp !== 1'b1 || enemy_active !== 4'b0001 || ys(0) !== 12'd550) begin errors++; $display("FAIL game_restart got sp=%b act=%b y0=%0d exp 1 0001 550", sp, enemy_active, ys(0)); end
    endtask

    task automatic test_reset_move;
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy_pre got %b exp 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (enemy_active !== 4'b0000 || enemy_x !== 48'd0 || enemy_y !== 48'd0 || busy !== 1'b0) begin errors++; $display("FAIL rst_move got act=%b x=%h y=%h busy=%b exp all 0", enemy_active, enemy_x, enemy_y, busy); end
        @(negedge clk); rst_n = 1'b1;
        run(59);
        checks++; if (nsp !== 0 || enemy_active !== 4'b0000) begin errors++; $display("FAIL rst_early got n=%0d act=%b exp 0 0000", nsp, enemy_active); end
        frame(0, 3'd0);
        checks++; if (sp !== 1'b1 || enemy_active !== 4'b0001 || ys(0) !== 12'd350) begin errors++; $display("FAIL rst_spawn got sp=%b act=%b y0=%0d exp 1 0001 350", sp, enemy_active, ys(0)); end
    endtask

    initial begin
        test_reset;
        test_first_spawn;
        test_second_spawn;
        test_full;
        test_escape;
        test_hit_races;
        test_game_off;
        test_reset_move;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/enemy_spawn_ctrl.md
Name: enemy_spawn_ctrl

Overview:
- Scheduler for the enemy fleet. Owns NUM_ENEMY enemy slots.
- Once per frame it advances every active enemy leftward, retires enemies that reach the left edge, and spawns new enemies into free slots at a fixed frame interval.
- New enemies are placed on lanes taken from the game's fixed lane sequence.
- Sits between the frame-timing logic and the collision/render logic. Supplies packed X/Y positions and the active mask.

Parameters:
- NUM_ENEMY, 4, number of enemy slots (2..8).
- SPAWN_X, 12'd1000, X coordinate given to a newly spawned enemy.
- LEFT_EDGE, 12'd30, an enemy with X <= LEFT_EDGE has escaped.
- STEP, 12'd4, pixels moved left per frame.
- SPAWN_INTERVAL, 60, frames between spawn attempts (>= 1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- game_en  in  1  high while the game is running.
- hit_valid  in  1  collision logic reports an enemy destroyed this cycle.
- hit_idx  in  3  slot index of the destroyed enemy.
- enemy_x  out  12*NUM_ENEMY  packed X, slot i at [12i+11:12i].
- enemy_y  out  12*NUM_ENEMY  packed Y, same packing.
- enemy_active  out  NUM_ENEMY  per-slot valid.
- spawn_pulse  out  1  one-cycle pulse when a spawn occurs.
- escape_pulse  out  1  one-cycle pulse when one or more enemies escape in a frame.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; all X/Y=0; enemy_active=0; spawn counter=0; lane index=0; pulses=0.
  - Reset takes effect in any state, including mid-sequence.
- FSM states: IDLE, MOVE, RETIRE, SPAWN. Each state lasts exactly one cycle.
- IDLE:
  - frame_tick && game_en -> MOVE.
  - frame_tick seen in any other state is dropped. It cannot normally occur, since a sequence lasts 3 cycles.
- MOVE:
  - Each active slot: X <= (X >= STEP) ? X-STEP : 0, i.e. unsigned saturating subtract.
  - Spawn counter increments, saturating at SPAWN_INTERVAL.
  - -> RETIRE.
- RETIRE:
  - Each active slot with X <= LEFT_EDGE is cleared.
  - escape_pulse=1 on the next cycle if any slot was cleared.
  - X/Y of a cleared slot are held, not zeroed.
  - -> SPAWN.
- SPAWN:
  - If counter == SPAWN_INTERVAL and any slot is free: the lowest-index free slot gets X=SPAWN_X, Y=lane_table[lane_idx], active=1.
  - On a spawn: lane_idx advances modulo 7, counter clears, spawn_pulse=1 on the next cycle.
  - If no slot is free, the counter holds at SPAWN_INTERVAL and the spawn retries next frame.
  - -> IDLE.
- Lane table, in order, index 0..6: 350, 550, 250, 450, 370, 630, 130, then wraps to 350.
- Hits:
  - hit_valid is honoured in every state. It clears active[hit_idx] at the clock edge.
  - A hit on an inactive slot, or hit_idx >= NUM_ENEMY, is ignored.
  - Same cycle as a RETIRE clear of that slot: slot is cleared once. escape_pulse still fires, because the slot met the edge condition.
  - Same cycle as a SPAWN into that slot: the slot was free, so the hit is ignored and the spawn wins.
  - Same cycle as MOVE: the hit clears the slot and the MOVE update is irrelevant.
- game_en low:
  - Sampled every cycle. Any in-flight sequence completes normally.
  - When game_en is low in IDLE: all active bits clear, spawn counter clears. Lane index is kept so lane order continues across games.
- Outputs are registered. Position changes are visible the cycle after the state that makes them.

Optional Feature:
- Macro LFSR_LANE_EN.
- Defined:
  - A 10-bit Fibonacci LFSR (taps 10,7; seed 10'd233 on reset) steps once per frame_tick.
  - Spawn lane = lane_table[lfsr % 7]. lane_idx is unused.
  - An all-zero LFSR state reloads the seed.
- Undefined: fixed sequential lane order as above, and no LFSR logic is synthesised.

Test Plan:
- Reset, then game_en=1, 60 frame_ticks -> on tick 60 slot0 active, X=1000, Y=350; spawn_pulse is one cycle wide.
- Continue 60 more frames -> slot0 X=760, slot1 spawned with Y=550. After 7 total spawns (free slots permitting), the 8th Y=350 (wrap).
- Drive an enemy to X=32 -> next frame X=28, retired in RETIRE, escape_pulse=1 for one cycle, enemy_active[0]=0.
- All 4 slots active at spawn time -> no spawn, counter held. Clear slot2 by hit -> spawn lands in slot2 on the next frame.
- hit_valid with hit_idx=1 asserted in the SPAWN cycle where slot1 is the target -> slot1 ends active with new X/Y. hit_idx=5 -> no effect.
- Assert rst_n low during MOVE -> all outputs zero immediately. After release, no spawn occurs until 60 frames have elapsed.
